// File: rtl/mod_pingpong_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_pingpong_wr_ctrl_if
// Purpose  : Bundles the mapper-side handshake, the ping-pong memory write
//            port and the symbol/bank control signals of the ping-pong write
//            controller.
// Ports    : slave  - controller view (mapper/read-side inputs in,
//                     memory write and control outputs out)
//            master - environment view (mirror of slave)
// Revision : 1.0 - initial release
// ============================================================================
interface mod_pingpong_wr_ctrl_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11
);
  // Mapper side
  logic                  sym_start;
  logic [ADDR_WIDTH-1:0] sym_len;
  logic                  mod_valid_in;
  logic [DATA_WIDTH-1:0] mod_data_in;
  logic                  mod_ready;
  // Read side
  logic                  bank_release;
  // Memory write port and symbol controls
  logic                  write_enable;
  logic                  Mod_Valid_OUT;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  MOD_DONE;
  logic                  PINGPONG_SWITCH;
  logic [ADDR_WIDTH-1:0] Last_addr;
  logic                  wr_bank;
  logic [1:0]            banks_full;
  logic                  err;

  modport slave (
    input  sym_start, sym_len, mod_valid_in, mod_data_in, bank_release,
    output mod_ready, write_enable, Mod_Valid_OUT, write_addr, data_out,
           MOD_DONE, PINGPONG_SWITCH, Last_addr, wr_bank, banks_full, err
  );

  modport master (
    output sym_start, sym_len, mod_valid_in, mod_data_in, bank_release,
    input  mod_ready, write_enable, Mod_Valid_OUT, write_addr, data_out,
           MOD_DONE, PINGPONG_SWITCH, Last_addr, wr_bank, banks_full, err
  );
endinterface
`default_nettype wire

// File: rtl/mod_pingpong_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mod_pingpong_wr_ctrl
// Purpose  : Write-side controller for the mapper->FFT ping-pong symbol
//            memory. Accepts mapper samples under valid/ready, produces
//            1-based write addresses and strobes, per-symbol completion
//            pulses (MOD_DONE / PINGPONG_SWITCH / Last_addr) and tracks
//            occupancy of the two banks, stalling the mapper when both
//            banks hold undrained symbols.
// Ports    : CLK  - clock
//            RST  - asynchronous active-low reset
//            bus  - mod_pingpong_wr_ctrl_if.slave (handshake, memory write
//                   port, bank accounting and error flag)
// Revision : 1.0 - initial release
// ============================================================================
module mod_pingpong_wr_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int MEM_DEPTH  = 1200,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  mod_pingpong_wr_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] c_mem_depth = ADDR_WIDTH'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BANK = 2'd1,
    S_WRITE     = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_len;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_last;
  logic                  r_wr_bank;
  logic [1:0]            r_banks_full;
  logic                  r_err;

  logic                  w_ready;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_cnt_inc;
  logic                  w_len_ok;
  logic                  w_done_inc;
  logic                  w_rel_ok;
  logic [1:0]            w_bf_next;
  logic                  w_bank_avail;
  logic                  w_load;
  logic                  w_err_set;

  assign w_ready    = (r_state == S_WRITE);
  assign w_accept   = bus.mod_valid_in && w_ready;
  assign w_cnt_inc  = r_cnt + ADDR_WIDTH'(1);
  assign w_len_ok   = (bus.sym_len != '0) && (bus.sym_len <= c_mem_depth);
  assign w_done_inc = (r_state == S_DONE);
  // A release with nothing completed is a protocol error and does not count.
  assign w_rel_ok   = bus.bank_release && (r_banks_full != 2'd0);
  assign w_bf_next  = r_banks_full + {1'b0, w_done_inc} - {1'b0, w_rel_ok};
  // Availability is judged on the occupancy after this cycle's completion
  // and release, so a start in DONE cannot over-fill and a release seen in
  // WAIT_BANK lets writing resume on the very next cycle.
  assign w_bank_avail = (w_bf_next < 2'd2);

  assign w_err_set =
      (bus.sym_start && ((r_state == S_IDLE) || (r_state == S_DONE)) && !w_len_ok)
    || (bus.sym_start && ((r_state == S_WAIT_BANK) || (r_state == S_WRITE)))
    || (bus.mod_valid_in && !w_ready)
    || (bus.bank_release && (r_banks_full == 2'd0));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state; DONE accepts a new start exactly like IDLE
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
        if (bus.sym_start && w_len_ok) begin
          w_load      = 1'b1;
          w_state_nxt = w_bank_avail ? S_WRITE : S_WAIT_BANK;
        end
      end
      S_WAIT_BANK: begin
        if (w_bank_avail) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_accept && (w_cnt_inc == r_len)) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath, completion controls and bank accounting
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt        <= '0;
      r_len        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_last       <= '0;
      r_wr_bank    <= 1'b1;
      r_banks_full <= 2'd0;
      r_err        <= 1'b0;
    end else begin
      if (w_load) begin
        r_len <= bus.sym_len;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
      end

      // Address and data hold their last values through gaps.
      r_we <= w_accept;
      if (w_accept) begin
        r_addr <= w_cnt_inc;
        r_data <= bus.mod_data_in;
      end

      // r_len still holds the finishing symbol's length here even if a new
      // start loads r_len on this same edge.
      r_done <= w_done_inc;
      if (w_done_inc) begin
        r_last    <= r_len;
        r_wr_bank <= ~r_wr_bank;
      end

      r_banks_full <= w_bf_next;

      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.mod_ready       = w_ready;
  assign bus.write_enable    = r_we;
  assign bus.Mod_Valid_OUT   = r_we;
  assign bus.write_addr      = r_addr;
  assign bus.data_out        = r_data;
  assign bus.MOD_DONE        = r_done;
  assign bus.PINGPONG_SWITCH = r_done;
  assign bus.Last_addr       = r_last;
  assign bus.wr_bank         = r_wr_bank;
  assign bus.banks_full      = r_banks_full;
  assign bus.err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mod_pingpong_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_pingpong_wr_ctrl
// Purpose  : Self-checking bench for mod_pingpong_wr_ctrl. Directed steps
//            push expected writes and completions to scoreboard queues; a
//            monitor pops and compares them when the controller produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_pingpong_wr_ctrl;
  localparam int DW = 18;
  localparam int AW = 11;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mod_pingpong_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mod_pingpong_wr_ctrl #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (1200),
    .ADDR_WIDTH(AW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] last;
  } done_t;

  wr_t   wq[$];
  done_t dq[$];
  wr_t   w_e;
  done_t d_e;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit m_bank = 1'b1;
  int m_bf   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_symbol(input int len);
    bus.sym_start = 1'b1;
    bus.sym_len   = AW'(len);
    tick();
    bus.sym_start = 1'b0;
    bus.sym_len   = '1;  // length must already be latched
  endtask

  // Offer 'count' samples; each accepted one is expected on the memory port
  // one cycle later, and the symbol's last one yields MOD_DONE a cycle after.
  task automatic feed(input int count, input int len, input int d0, input int dstep, input bit gaps);
    int k      = 0;
    int budget = 4 * count + 50;
    bit phase  = 1'b1;
    while (k < count && budget > 0) begin
      if (bus.mod_ready && (!gaps || phase)) begin
        bus.mod_valid_in = 1'b1;
        bus.mod_data_in  = DW'(d0 + k * dstep);
        wq.push_back('{cyc + 1, AW'(k + 1), DW'(d0 + k * dstep)});
        if (k + 1 == len) dq.push_back('{cyc + 2, AW'(len)});
        k++;
      end else begin
        bus.mod_valid_in = 1'b0;
      end
      phase = !phase;
      tick();
      budget--;
    end
    bus.mod_valid_in = 1'b0;
    if (k < count) check("feed_timeout", k, count);
  endtask

  task automatic wait_done();
    int b = 10;
    while (dq.size() > 0 && b > 0) begin
      tick();
      b--;
    end
    check("done_timeout", dq.size(), 0);
  endtask

  task automatic release_bank();
    bus.bank_release = 1'b1;
    tick();
    bus.bank_release = 1'b0;
  endtask

  task automatic check_banks(input string tag);
    check({tag, "_banks_full"}, bus.banks_full, m_bf);
    check({tag, "_wr_bank"}, bus.wr_bank, m_bank);
  endtask

  // Scoreboard monitor, sampling on the inactive edge
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.write_enable || bus.Mod_Valid_OUT) begin
        check("write_expected", (wq.size() != 0), 1);
        if (wq.size() != 0) begin
          w_e = wq.pop_front();
          check("write_cycle", cyc, w_e.cyc);
          check("write_addr", bus.write_addr, w_e.addr);
          check("data_out", bus.data_out, w_e.data);
          check("write_enable", bus.write_enable, 1);
          check("mod_valid_out", bus.Mod_Valid_OUT, 1);
        end
      end
      if (bus.MOD_DONE || bus.PINGPONG_SWITCH) begin
        check("done_expected", (dq.size() != 0), 1);
        if (dq.size() != 0) begin
          d_e = dq.pop_front();
          check("done_cycle", cyc, d_e.cyc);
          check("last_addr", bus.Last_addr, d_e.last);
          check("mod_done", bus.MOD_DONE, 1);
          check("pingpong_switch", bus.PINGPONG_SWITCH, 1);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_we"}, bus.write_enable, 0);
    check({tag, "_mvo"}, bus.Mod_Valid_OUT, 0);
    check({tag, "_addr"}, bus.write_addr, 0);
    check({tag, "_data"}, bus.data_out, 0);
    check({tag, "_done"}, bus.MOD_DONE, 0);
    check({tag, "_pps"}, bus.PINGPONG_SWITCH, 0);
    check({tag, "_last"}, bus.Last_addr, 0);
    check({tag, "_wr_bank"}, bus.wr_bank, 1);
    check({tag, "_banks_full"}, bus.banks_full, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_ready"}, bus.mod_ready, 0);
  endtask

  initial begin
    bus.sym_start    = 1'b0;
    bus.sym_len      = '0;
    bus.mod_valid_in = 1'b0;
    bus.mod_data_in  = '0;
    bus.bank_release = 1'b0;
    repeat (2) tick();
    check_reset_state("reset");
    RST = 1'b1;
    tick();

    // Length-4 symbol, valid held high
    start_symbol(4);
    feed(4, 4, 'h11, 1, 1'b0);
    wait_done();
    m_bank = 1'b0; m_bf = 1;
    check_banks("s1");
    check("s1_hold_addr", bus.write_addr, 4);
    check("s1_hold_data", bus.data_out, 'h14);
    check("s1_we_low", bus.write_enable, 0);
    release_bank();
    m_bf = 0;
    check_banks("s1_rel");

    // Length-4 symbol with valid toggling
    start_symbol(4);
    feed(4, 4, 'h21, 1, 1'b1);
    wait_done();
    m_bank = 1'b1; m_bf = 1;
    check_banks("s2");

    // Completion coincident with a release while one bank is full
    start_symbol(2);
    feed(2, 2, 'h31, 1, 1'b0);
    release_bank();
    check("coincide_bf_at_done", bus.banks_full, 1);
    wait_done();
    m_bank = 1'b0;
    check_banks("coincide");
    release_bank();
    m_bf = 0;

    // Fill both banks, then stall until a release
    start_symbol(3);
    feed(3, 3, 'h41, 1, 1'b0);
    wait_done();
    m_bank = 1'b1; m_bf = 1;
    start_symbol(5);
    feed(5, 5, 'h51, 1, 1'b0);
    wait_done();
    m_bank = 1'b0; m_bf = 2;
    check_banks("full");
    start_symbol(2);
    for (int i = 0; i < 3; i++) begin
      check("wait_ready", bus.mod_ready, 0);
      tick();
    end
    release_bank();
    check("resume_ready", bus.mod_ready, 1);
    check("resume_bf", bus.banks_full, 1);
    feed(2, 2, 'h61, 1, 1'b0);
    wait_done();
    m_bank = 1'b1; m_bf = 2;
    check_banks("third");
    start_symbol(1);
    tick();
    check("wait_ready2", bus.mod_ready, 0);
    release_bank();
    check("resume_ready2", bus.mod_ready, 1);
    feed(1, 1, 'h71, 1, 1'b0);
    wait_done();
    m_bank = 1'b0; m_bf = 2;
    check_banks("fourth");
    release_bank();
    release_bank();
    m_bf = 0;
    check_banks("drained");
    check("err_clean", bus.err, 0);

    // Illegal lengths, then the maximum legal length
    start_symbol(0);
    check("len0_ready", bus.mod_ready, 0);
    check("len0_err", bus.err, 1);
    start_symbol(1201);
    tick();
    check("len1201_ready", bus.mod_ready, 0);
    start_symbol(1200);
    feed(1200, 1200, 'h100, 3, 1'b0);
    wait_done();
    m_bank = 1'b1; m_bf = 1;
    check_banks("max");
    check("max_last", bus.Last_addr, 1200);
    release_bank();
    m_bf = 0;

    // Reset in the middle of a symbol
    start_symbol(6);
    feed(2, 6, 'h81, 1, 1'b0);
    tick();
    RST = 1'b0;
    #1;
    check_reset_state("midrst");
    m_bank = 1'b1; m_bf = 0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    start_symbol(3);
    feed(3, 3, 'h91, 1, 1'b0);
    wait_done();
    m_bank = 1'b0; m_bf = 1;
    check_banks("after_rst");

    tick();
    check("write_queue_empty", wq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
